// File: rtl/rf_pkg.sv
// Shared widths and the buffered MDU result entry type for the register-file
// write arbiter.
package rf_pkg;
  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } rf_entry_t;
endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO holding MDU results until a register-file write slot
// is free. Simultaneous push and pop are accepted when full.
module rf_arb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  rf_entry_t                    wdata_i,
  output rf_entry_t                    rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  rf_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between the WB stage and buffered MDU
// results, tracking outstanding MDU destinations in a scoreboard.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_we,
  input  logic [REG_AW-1:0]   wb_dest,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                mdu_valid,
  input  logic [REG_AW-1:0]   mdu_dest,
  input  logic [DATA_W-1:0]   mdu_data,
  output logic                mdu_ready,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_dest,
  input  logic                dec_valid,
  input  logic [REG_AW-1:0]   dec_src1,
  input  logic [REG_AW-1:0]   dec_src2,
  input  logic [REG_AW-1:0]   dec_dest,
  output logic                hazard_stall,
  output logic                pipe_stall,
  output logic [NUM_REGS-1:0] busy,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_dest,
  output logic [DATA_W-1:0]   rf_wdata
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  rf_entry_t           head, push_entry;
  logic                full, empty, push, pop, wb_grant;
  logic [CW-1:0]       count, count_next;
  logic [SW-1:0]       starve_q, starve_d;
  logic                pipe_stall_q, pipe_stall_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign push_entry = '{dest: mdu_dest, data: mdu_data};

  // Results aimed at r0 are acknowledged but never queued.
  assign push      = mdu_valid && !full && (mdu_dest != '0);
  assign wb_grant  = !pipe_stall_q && wb_we && (wb_dest != '0);
  assign pop       = !empty && !wb_grant;
  assign mdu_ready = !full;

  rf_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_dest  = '0;
    rf_wdata = '0;
    if (!rst && pop) begin
      rf_we    = 1'b1;
      rf_dest  = head.dest;
      rf_wdata = head.data;
    end else if (!rst && wb_grant) begin
      rf_we    = 1'b1;
      rf_dest  = wb_dest;
      rf_wdata = wb_data;
    end
  end

  // pipe_stall is a flop tracking the next-cycle starve/full condition, so it
  // drops one cycle after the grant that relieves it.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    starve_d   = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
    pipe_stall_d = (starve_d >= SW'(STARVE_LIMIT-1)) || (count_next == CW'(FIFO_DEPTH));
  end

  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head.dest] = 1'b0;
    end
    if (iss_valid && (iss_dest != '0)) begin
      busy_d[iss_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      pipe_stall_q <= 1'b0;
      busy_q       <= '0;
    end else begin
      starve_q     <= starve_d;
      pipe_stall_q <= pipe_stall_d;
      busy_q       <= busy_d;
    end
  end

  assign pipe_stall   = pipe_stall_q;
  assign busy         = busy_q;
  assign hazard_stall = !rst && dec_valid &&
                        (busy_q[dec_src1] || busy_q[dec_src2] || busy_q[dec_dest]);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic        dec_valid;
  logic [4:0]  dec_src1;
  logic [4:0]  dec_src2;
  logic [4:0]  dec_dest;
  logic        hazard_stall;
  logic        pipe_stall;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_dest;
  logic [31:0] rf_wdata;

  int passCount  = 0;
  int checkCount = 0;

  rf_write_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_we        (wb_we),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .mdu_valid    (mdu_valid),
    .mdu_dest     (mdu_dest),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .iss_valid    (iss_valid),
    .iss_dest     (iss_dest),
    .dec_valid    (dec_valid),
    .dec_src1     (dec_src1),
    .dec_src2     (dec_src2),
    .dec_dest     (dec_dest),
    .hazard_stall (hazard_stall),
    .pipe_stall   (pipe_stall),
    .busy         (busy),
    .rf_we        (rf_we),
    .rf_dest      (rf_dest),
    .rf_wdata     (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idleInputs();
    wb_we = 1'b0; wb_dest = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_dest = '0; mdu_data = '0;
    iss_valid = 1'b0; iss_dest = '0;
    dec_valid = 1'b0; dec_src1 = '0; dec_src2 = '0; dec_dest = '0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Random traffic; the WB side sometimes honours pipe_stall with a bubble.
  task automatic applyStimulus();
    rst       = ($urandom_range(0, 99) == 0);
    wb_we     = ($urandom_range(0, 9) < 6);
    if (pipe_stall && $urandom_range(0, 1) == 1) wb_we = 1'b0;
    wb_dest   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    wb_data   = $urandom;
    mdu_valid = ($urandom_range(0, 9) < 4);
    mdu_dest  = 5'($urandom_range(0, 15));
    mdu_data  = $urandom;
    iss_valid = ($urandom_range(0, 9) < 3);
    iss_dest  = 5'($urandom_range(0, 15));
    dec_valid = ($urandom_range(0, 1) == 1);
    dec_src1  = 5'($urandom_range(0, 15));
    dec_src2  = 5'($urandom_range(0, 15));
    dec_dest  = 5'($urandom_range(0, 15));
  endtask

  // Behavioural model: a queue of pending results, a busy array, and a count
  // of consecutive cycles the queue head has been passed over.
  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        mQueue[$];
  bit          mBusy[32];
  int          mStarve    = 0;
  bit          mStall     = 1'b0;
  bit          modelValid = 1'b0;
  bit          wbWins, fifoWins, expWe, wasEmpty, hasRoom;
  logic [4:0]  expDest;
  logic [31:0] expData, expBusy;
  bit          expHazard;

  always @(negedge clk) begin
    wbWins   = !mStall && wb_we && (wb_dest != 5'd0);
    fifoWins = (mQueue.size() > 0) && !wbWins;
    if (rst) begin
      checkOutput("rf_we_in_reset", 32'(rf_we), 32'd0);
      checkOutput("hazard_in_reset", 32'(hazard_stall), 32'd0);
    end else if (modelValid) begin
      expWe = wbWins || fifoWins;
      checkOutput("rf_we", 32'(rf_we), 32'(expWe));
      if (expWe) begin
        expDest = fifoWins ? mQueue[0].dest : wb_dest;
        expData = fifoWins ? mQueue[0].data : wb_data;
        checkOutput("rf_dest", 32'(rf_dest), 32'(expDest));
        checkOutput("rf_wdata", rf_wdata, expData);
      end
      for (int r = 0; r < 32; r++) expBusy[r] = mBusy[r];
      expHazard = dec_valid && (mBusy[dec_src1] || mBusy[dec_src2] || mBusy[dec_dest]);
      checkOutput("mdu_ready", 32'(mdu_ready), 32'(mQueue.size() < DEPTH));
      checkOutput("pipe_stall", 32'(pipe_stall), 32'(mStall));
      checkOutput("busy", busy, expBusy);
      checkOutput("hazard_stall", 32'(hazard_stall), 32'(expHazard));
    end

    if (rst) begin
      mQueue.delete();
      for (int r = 0; r < 32; r++) mBusy[r] = 1'b0;
      mStarve    = 0;
      mStall     = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      wasEmpty = (mQueue.size() == 0);
      hasRoom  = (mQueue.size() < DEPTH);
      if (fifoWins) begin
        mBusy[mQueue[0].dest] = 1'b0;
        void'(mQueue.pop_front());
      end
      if (mdu_valid && hasRoom && mdu_dest != 5'd0) mQueue.push_back('{dest: mdu_dest, data: mdu_data});
      if (iss_valid && iss_dest != 5'd0) mBusy[iss_dest] = 1'b1;
      mStarve = (wasEmpty || fifoWins) ? 0 : mStarve + 1;
      mStall  = (mStarve >= LIMIT - 1) || (mQueue.size() == DEPTH);
    end
  end

  initial begin
    idleInputs();
    rst = 1'b1;
    stepCycle();
    stepCycle();

    // Idle after reset
    rst = 1'b0; dec_valid = 1'b1; dec_src1 = 5'd5; #1;
    checkOutput("t1_rf_we", 32'(rf_we), 32'd0);
    checkOutput("t1_busy", busy, 32'd0);
    checkOutput("t1_mdu_ready", 32'(mdu_ready), 32'd1);
    checkOutput("t1_pipe_stall", 32'(pipe_stall), 32'd0);
    checkOutput("t1_hazard", 32'(hazard_stall), 32'd0);

    // Single MDU result to r5 through an idle write port
    iss_valid = 1'b1; iss_dest = 5'd5;
    stepCycle();
    iss_valid = 1'b0; mdu_valid = 1'b1; mdu_dest = 5'd5; mdu_data = 32'h1234; #1;
    checkOutput("t2_hazard_set", 32'(hazard_stall), 32'd1);
    checkOutput("t2_busy_set", busy, 32'h0000_0020);
    checkOutput("t2_no_write_on_push", 32'(rf_we), 32'd0);
    stepCycle();
    mdu_valid = 1'b0; #1;
    checkOutput("t2_rf_we", 32'(rf_we), 32'd1);
    checkOutput("t2_rf_dest", 32'(rf_dest), 32'd5);
    checkOutput("t2_rf_wdata", rf_wdata, 32'h1234);
    checkOutput("t2_hazard_hold", 32'(hazard_stall), 32'd1);
    stepCycle();

    // WB hogs the port while r7 waits for the starve stall
    dec_valid = 1'b0; wb_we = 1'b1; wb_dest = 5'd3; wb_data = 32'hAAAA_0003;
    mdu_valid = 1'b1; mdu_dest = 5'd7; mdu_data = 32'h7777;
    iss_valid = 1'b1; iss_dest = 5'd7; #1;
    checkOutput("t3_busy_clear5", busy, 32'd0);
    checkOutput("t3_rf_dest_wb", 32'(rf_dest), 32'd3);
    stepCycle();
    mdu_valid = 1'b0; iss_valid = 1'b0;
    for (int i = 0; i < LIMIT - 1; i++) begin
      #1;
      checkOutput("t3_no_stall_yet", 32'(pipe_stall), 32'd0);
      checkOutput("t3_wb_wins", 32'(rf_dest), 32'd3);
      stepCycle();
    end
    #1;
    checkOutput("t3_stall", 32'(pipe_stall), 32'd1);
    checkOutput("t3_fifo_dest", 32'(rf_dest), 32'd7);
    checkOutput("t3_fifo_data", rf_wdata, 32'h7777);
    checkOutput("t3_busy7", busy, 32'h0000_0080);
    stepCycle();

    // Two pushes fill the FIFO, then it drains in order
    mdu_valid = 1'b1; mdu_dest = 5'd10; mdu_data = 32'hA; #1;
    checkOutput("t3_stall_drop", 32'(pipe_stall), 32'd0);
    checkOutput("t3_wb_back", 32'(rf_dest), 32'd3);
    checkOutput("t3_busy_clear7", busy, 32'd0);
    stepCycle();
    mdu_dest = 5'd11; mdu_data = 32'hB; #1;
    checkOutput("t4_ready_one", 32'(mdu_ready), 32'd1);
    stepCycle();
    mdu_valid = 1'b0; #1;
    checkOutput("t4_full_ready", 32'(mdu_ready), 32'd0);
    checkOutput("t4_full_stall", 32'(pipe_stall), 32'd1);
    checkOutput("t4_first_dest", 32'(rf_dest), 32'd10);
    checkOutput("t4_first_data", rf_wdata, 32'hA);
    stepCycle();
    wb_we = 1'b0; #1;
    checkOutput("t4_stall_drop", 32'(pipe_stall), 32'd0);
    checkOutput("t4_second_dest", 32'(rf_dest), 32'd11);
    checkOutput("t4_second_data", rf_wdata, 32'hB);
    stepCycle();

    // wb_dest 0 leaves the slot free; MDU results to r0 are dropped
    mdu_valid = 1'b1; mdu_dest = 5'd12; mdu_data = 32'hC; #1;
    checkOutput("t5_idle_we", 32'(rf_we), 32'd0);
    stepCycle();
    mdu_valid = 1'b0; wb_we = 1'b1; wb_dest = 5'd0; wb_data = 32'hDEAD; #1;
    checkOutput("t5_r0_slot_we", 32'(rf_we), 32'd1);
    checkOutput("t5_r0_slot_dest", 32'(rf_dest), 32'd12);
    checkOutput("t5_r0_slot_data", rf_wdata, 32'hC);
    stepCycle();
    wb_we = 1'b0; mdu_valid = 1'b1; mdu_dest = 5'd0; mdu_data = 32'hBAD; #1;
    checkOutput("t5_empty_we", 32'(rf_we), 32'd0);
    stepCycle();
    mdu_valid = 1'b0; #1;
    checkOutput("t5_r0_dropped", 32'(rf_we), 32'd0);
    checkOutput("t5_ready", 32'(mdu_ready), 32'd1);
    stepCycle();

    // Re-issue to r9 in the same cycle as r9 is written
    mdu_valid = 1'b1; mdu_dest = 5'd9; mdu_data = 32'h99; iss_valid = 1'b1; iss_dest = 5'd9;
    stepCycle();
    mdu_valid = 1'b0; #1;
    checkOutput("t6_r9_write", 32'(rf_dest), 32'd9);
    checkOutput("t6_r9_busy_before", busy, 32'h0000_0200);
    stepCycle();
    iss_valid = 1'b0; #1;
    checkOutput("t6_set_wins", busy, 32'h0000_0200);
    wb_we = 1'b1; wb_dest = 5'd3; mdu_valid = 1'b1; mdu_dest = 5'd13; mdu_data = 32'hD;
    iss_valid = 1'b1; iss_dest = 5'd13;
    stepCycle();
    mdu_dest = 5'd14; iss_dest = 5'd14;
    stepCycle();

    // Reset with two queued entries
    mdu_valid = 1'b0; iss_valid = 1'b0; rst = 1'b1; dec_valid = 1'b1; dec_src1 = 5'd9; #1;
    checkOutput("t6_full_before_rst", 32'(mdu_ready), 32'd0);
    checkOutput("t6_rst_we", 32'(rf_we), 32'd0);
    checkOutput("t6_rst_hazard", 32'(hazard_stall), 32'd0);
    stepCycle();
    rst = 1'b0; wb_we = 1'b0; #1;
    checkOutput("t6_rst_busy", busy, 32'd0);
    checkOutput("t6_rst_ready", 32'(mdu_ready), 32'd1);
    checkOutput("t6_rst_stall", 32'(pipe_stall), 32'd0);
    checkOutput("t6_rst_empty", 32'(rf_we), 32'd0);
    stepCycle();
    dec_valid = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      applyStimulus();
      stepCycle();
    end
    idleInputs();
    rst = 1'b0;
    repeat (8) stepCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
